// File: rtl/weight_addr_gen_nd.sv
`default_nettype none
// =============================================================================
// Module  : weight_addr_gen_nd
// Brief   : Nested mixed-radix loop address generator for one weight-buffer bank.
// Revision: 1.0 - initial release
// =============================================================================
module weight_addr_gen_nd #(
   parameter int BANK_ADDR_WIDTH = 32,
   parameter int NUM_LOOPS       = 5,
   parameter int BOUND_WIDTH     = 8,
   parameter int REPEAT_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             config_en,
   input  logic [NUM_LOOPS*BOUND_WIDTH-1:0] config_bounds,
   input  logic [BANK_ADDR_WIDTH-1:0]       config_base,
   input  logic [REPEAT_WIDTH-1:0]          config_repeat,
   output logic                             config_err,
   input  logic                             start,
   output logic                             busy,
   output logic                             addr_valid,
   input  logic                             addr_ready,
   output logic [BANK_ADDR_WIDTH-1:0]       addr,
   output logic [NUM_LOOPS*BOUND_WIDTH-1:0] loop_idx,
   output logic                             last_in_pass,
   output logic                             last,
   output logic                             done
);

   localparam int c_SW = BANK_ADDR_WIDTH + 1;
   localparam int c_MW = BANK_ADDR_WIDTH + BOUND_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic [NUM_LOOPS*BOUND_WIDTH-1:0] r_bounds;
   logic [NUM_LOOPS*BOUND_WIDTH-1:0] r_idx;
   logic [NUM_LOOPS*BOUND_WIDTH-1:0] w_idx_nxt;
   logic [BANK_ADDR_WIDTH-1:0]       r_base;
   logic [BANK_ADDR_WIDTH-1:0]       r_addr;
   logic [REPEAT_WIDTH-1:0]          r_repeat;
   logic [REPEAT_WIDTH-1:0]          r_pass_cnt;
   logic                             r_cfg_pending;
   logic                             r_config_err;

   logic [NUM_LOOPS:0]               w_carry;
   logic [NUM_LOOPS-1:0]             w_wrap;
   logic [NUM_LOOPS-1:0]             w_zero;
   logic [NUM_LOOPS:0]               w_ovf;
   logic [c_SW-1:0]                  w_prod [0:NUM_LOOPS];
   logic [c_SW-1:0]                  w_sum;
   logic                             w_run;
   logic                             w_hs;
   logic                             w_pass_end;
   logic                             w_last;
   logic                             w_start_ok;
   logic                             w_cfg_err;

   // Per-loop wrap/carry chain; loop 0 advances on every handshake.
   assign w_carry[0] = 1'b1;
   generate
      for (genvar k = 0; k < NUM_LOOPS; k++) begin : g_loop
         logic [BOUND_WIDTH-1:0] w_bnd;
         logic [BOUND_WIDTH-1:0] w_cur;
         assign w_bnd          = r_bounds[k*BOUND_WIDTH +: BOUND_WIDTH];
         assign w_cur          = r_idx[k*BOUND_WIDTH +: BOUND_WIDTH];
         assign w_wrap[k]      = (w_cur == (w_bnd - BOUND_WIDTH'(1)));
         assign w_carry[k+1]   = w_carry[k] & w_wrap[k];
         assign w_idx_nxt[k*BOUND_WIDTH +: BOUND_WIDTH] =
            !w_carry[k] ? w_cur :
            (w_wrap[k] ? '0 : w_cur + BOUND_WIDTH'(1));
      end
   endgenerate

   // Bound product with sticky overflow; the clamp keeps the product within c_SW bits.
   assign w_prod[0] = c_SW'(1);
   assign w_ovf[0]  = 1'b0;
   generate
      for (genvar k = 0; k < NUM_LOOPS; k++) begin : g_prod
         logic [c_MW-1:0] w_mul;
         logic            w_big;
         assign w_mul = {{BOUND_WIDTH{1'b0}}, w_prod[k]} *
                        {{c_SW{1'b0}}, r_bounds[k*BOUND_WIDTH +: BOUND_WIDTH]};
         assign w_big       = |w_mul[c_MW-1:c_SW];
         assign w_prod[k+1] = w_big ? {1'b1, {BANK_ADDR_WIDTH{1'b0}}} : w_mul[c_SW-1:0];
         assign w_ovf[k+1]  = w_ovf[k] | w_big;
         assign w_zero[k]   = (r_bounds[k*BOUND_WIDTH +: BOUND_WIDTH] == '0);
      end
   endgenerate

   assign w_sum     = {1'b0, r_base} + w_prod[NUM_LOOPS] - c_SW'(1);
   assign w_cfg_err = (|w_zero) | w_ovf[NUM_LOOPS] | w_sum[BANK_ADDR_WIDTH];

   assign w_run      = (r_state == S_RUN);
   assign w_hs       = w_run & addr_ready;
   assign w_pass_end = w_carry[NUM_LOOPS];
   assign w_last     = w_pass_end & (r_pass_cnt == r_repeat);
   assign w_start_ok = (r_state == S_IDLE) & start & ~config_en &
                       ~r_cfg_pending & ~r_config_err;

   assign addr         = r_addr;
   assign loop_idx     = r_idx;
   assign config_err   = r_config_err;
   assign last_in_pass = w_run & w_pass_end;
   assign last         = w_run & w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      addr_valid  = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy       = 1'b1;
            addr_valid = 1'b1;
            if (w_hs && w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Config is only accepted while idle; legality is judged one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bounds      <= '0;
         r_base        <= '0;
         r_repeat      <= '0;
         r_cfg_pending <= 1'b0;
         r_config_err  <= 1'b1;
      end else begin
         r_cfg_pending <= config_en && (r_state == S_IDLE);
         if (config_en && (r_state == S_IDLE)) begin
            r_bounds <= config_bounds;
            r_base   <= config_base;
            r_repeat <= config_repeat;
         end
         if (r_cfg_pending) begin
            r_config_err <= w_cfg_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr     <= '0;
         r_idx      <= '0;
         r_pass_cnt <= '0;
      end else if (w_start_ok) begin
         r_addr     <= r_base;
         r_idx      <= '0;
         r_pass_cnt <= '0;
      end else if (w_hs) begin
         r_idx <= w_idx_nxt;
         if (w_last) begin
            r_addr     <= '0;
            r_pass_cnt <= '0;
         end else if (w_pass_end) begin
            r_addr     <= r_base;
            r_pass_cnt <= r_pass_cnt + REPEAT_WIDTH'(1);
         end else begin
            r_addr <= r_addr + BANK_ADDR_WIDTH'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_weight_addr_gen_nd.sv
`default_nettype none
// =============================================================================
// Module  : tb_weight_addr_gen_nd
// Brief   : Directed self-checking bench for weight_addr_gen_nd.
// Revision: 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_weight_addr_gen_nd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        config_en = 1'b0;
   logic [39:0] config_bounds = '0;
   logic [31:0] config_base = '0;
   logic [15:0] config_repeat = '0;
   logic        start = 1'b0;
   logic        addr_ready = 1'b0;
   logic        config_err;
   logic        busy;
   logic        addr_valid;
   logic [31:0] addr;
   logic [39:0] loop_idx;
   logic        last_in_pass;
   logic        last;
   logic        done;

   int checks = 0;
   int errors = 0;

   localparam logic [39:0] B1 = {8'd4, 8'd2, 8'd3, 8'd3, 8'd4};
   localparam logic [39:0] B3 = {8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
   localparam logic [39:0] B4 = {8'd1, 8'd1, 8'd1, 8'd4, 8'd4};

   weight_addr_gen_nd dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .config_en     (config_en),
      .config_bounds (config_bounds),
      .config_base   (config_base),
      .config_repeat (config_repeat),
      .config_err    (config_err),
      .start         (start),
      .busy          (busy),
      .addr_valid    (addr_valid),
      .addr_ready    (addr_ready),
      .addr          (addr),
      .loop_idx      (loop_idx),
      .last_in_pass  (last_in_pass),
      .last          (last),
      .done          (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input logic [39:0] b, input logic [31:0] base, input logic [15:0] rep);
      config_bounds = b;
      config_base   = base;
      config_repeat = rep;
      config_en     = 1'b1;
      tick();
      config_en = 1'b0;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [39:0] idx_of(input int n, input logic [39:0] b);
      logic [39:0] v;
      int r;
      int bk;
      v = '0;
      r = n;
      for (int k = 0; k < 5; k++) begin
         bk = int'(b[k*8 +: 8]);
         v[k*8 +: 8] = 8'(r % bk);
         r = r / bk;
      end
      return v;
   endfunction

   function automatic logic [127:0] expv(input logic v, input logic lip, input logic lst,
                                         input logic [31:0] a, input logic [39:0] idx);
      return 128'({v, lip, lst, a, idx});
   endfunction

   function automatic logic [127:0] obsv();
      return 128'({addr_valid, last_in_pass, last, addr, loop_idx});
   endfunction

   initial begin
      int n;

      // Reset state
      #12;
      chk("reset_outs", 128'({busy, addr_valid, done, last_in_pass, last, addr, loop_idx}), 128'(0));
      chk("reset_cfg_err", 128'(config_err), 128'(1));
      rst_n = 1'b1;
      tick();

      // Case 1: single pass of 288 addresses
      configure(B1, 32'd0, 16'd0);
      chk("c1_cfg_err", 128'(config_err), 128'(0));
      addr_ready = 1'b1;
      pulse_start();
      chk("c1_busy", 128'(busy), 128'(1));
      for (int i = 0; i < 288; i++) begin
         chk($sformatf("c1_step%0d", i), obsv(),
             expv(1'b1, i == 287, i == 287, 32'(i), idx_of(i, B1)));
         tick();
      end
      chk("c1_done", 128'({done, busy, addr_valid}), 128'(3'b110));
      tick();
      chk("c1_idle", 128'({done, busy}), 128'(0));

      // Case 2: three passes back to back
      configure(B1, 32'd0, 16'd2);
      pulse_start();
      for (int i = 0; i < 864; i++) begin
         chk($sformatf("c2_step%0d", i), obsv(),
             expv(1'b1, (i % 288) == 287, i == 863, 32'(i % 288), idx_of(i % 288, B1)));
         tick();
      end
      chk("c2_done", 128'({done, addr_valid}), 128'(2'b10));
      tick();

      // Case 3: base offset with random backpressure
      addr_ready = 1'b0;
      configure(B3, 32'd1000, 16'd0);
      pulse_start();
      n = 0;
      for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
         chk($sformatf("c3_cyc%0d", cyc), obsv(),
             expv(1'b1, n == 3, n == 3, 32'(1000 + n), idx_of(n, B3)));
         addr_ready = (cyc == 0) ? 1'b0 : ((cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1)));
         tick();
         if (addr_ready) n++;
      end
      chk("c3_count", 128'(n), 128'(4));
      chk("c3_done", 128'(done), 128'(1));
      addr_ready = 1'b1;
      tick();

      // Case 4: illegal configs, start latency, top-of-range legal config
      configure({8'd1, 8'd0, 8'd3, 8'd3, 8'd4}, 32'd0, 16'd0);
      chk("c4_zero_err", 128'(config_err), 128'(1));
      pulse_start();
      chk("c4_zero_nostart", 128'({busy, addr_valid}), 128'(0));
      configure(B4, 32'hFFFF_FFF6, 16'd0);
      chk("c4_ovf_err", 128'(config_err), 128'(1));
      pulse_start();
      chk("c4_ovf_nostart", 128'({busy, addr_valid}), 128'(0));
      config_bounds = B4;
      config_base   = 32'hFFFF_FFF0;
      config_repeat = 16'd0;
      config_en = 1'b1;
      tick();
      config_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("c4_latency_nostart", 128'({busy, addr_valid}), 128'(0));
      chk("c4_edge_err", 128'(config_err), 128'(0));
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("c4_step%0d", i), obsv(),
             expv(1'b1, i == 15, i == 15, 32'hFFFF_FFF0 + 32'(i), idx_of(i, B4)));
         tick();
      end
      chk("c4_done", 128'(done), 128'(1));
      tick();

      // Case 5: asynchronous reset mid-run
      configure(B1, 32'd0, 16'd0);
      pulse_start();
      for (int i = 0; i < 50; i++) tick();
      chk("c5_pre_reset", obsv(), expv(1'b1, 1'b0, 1'b0, 32'd50, idx_of(50, B1)));
      #2;
      rst_n = 1'b0;
      #1;
      chk("c5_async_outs", 128'({busy, addr_valid, done, last_in_pass, last, addr, loop_idx}), 128'(0));
      chk("c5_async_err", 128'(config_err), 128'(1));
      tick();
      tick();
      chk("c5_no_done", 128'({done, busy}), 128'(0));
      rst_n = 1'b1;
      tick();
      configure(B1, 32'd0, 16'd0);
      pulse_start();
      chk("c5_restart", obsv(), expv(1'b1, 1'b0, 1'b0, 32'd0, '0));
      for (int i = 0; i < 288; i++) tick();
      chk("c5_done", 128'(done), 128'(1));
      tick();

      // Case 6: start/config_en during a run are ignored
      configure(B3, 32'd500, 16'd0);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            start         = 1'b1;
            config_en     = 1'b1;
            config_bounds = {5{8'd3}};
            config_base   = 32'd0;
            config_repeat = 16'd5;
         end else begin
            start     = 1'b0;
            config_en = 1'b0;
         end
         chk($sformatf("c6_step%0d", i), obsv(),
             expv(1'b1, i == 3, i == 3, 32'(500 + i), idx_of(i, B3)));
         tick();
      end
      start     = 1'b0;
      config_en = 1'b0;
      chk("c6_done", 128'(done), 128'(1));
      tick();
      pulse_start();
      chk("c6_rerun", obsv(), expv(1'b1, 1'b0, 1'b0, 32'd500, '0));
      for (int i = 0; i < 4; i++) tick();
      chk("c6_rerun_done", 128'(done), 128'(1));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
